// File: rtl/int2flt_seq.sv
// Purpose: sequential 16-bit two's-complement integer to IEEE-754 half-float converter on a byte-wide data memory.
// Latency: 7 cycles + leading-zero shifts from start detect to ack (6 cycles for a zero input).
// Backpressure: none; memory reads/writes are single-cycle and a start seen while busy is ignored.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-low reset
//   req / ack       - conversion starts on req falling edge (IDLE only); ack pulses one cycle when done
//   dm_addr         - memory address (reads integer at IN_ADDR/IN_ADDR+1, writes result at OUT_ADDR/OUT_ADDR+1)
//   dm_wr_en        - memory write strobe, high only while writing the two result bytes
//   dm_wdata        - memory write byte
//   dm_rdata        - combinational memory read byte for the current dm_addr
module int2flt_seq #(
    parameter int AW       = 8,
    parameter int IN_ADDR  = 0,
    parameter int OUT_ADDR = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic [AW-1:0] dm_addr,
    output logic          dm_wr_en,
    output logic [7:0]    dm_wdata,
    input  logic [7:0]    dm_rdata
);

    localparam logic [AW-1:0] IN_HI  = AW'(IN_ADDR);
    localparam logic [AW-1:0] IN_LO  = AW'(IN_ADDR + 1);
    localparam logic [AW-1:0] OUT_HI = AW'(OUT_ADDR);
    localparam logic [AW-1:0] OUT_LO = AW'(OUT_ADDR + 1);

    typedef enum logic [3:0] {
        IDLE, RD_HI, RD_LO, ABS, NORM, ROUND, PACK, WR_HI, WR_LO, DONE
    } state_t;

    state_t      state, state_nxt;
    logic        req_q;
    logic        sign;
    logic [15:0] mag;
    logic [4:0]  exp_q;
    logic [9:0]  mant_q;
    logic [15:0] res_q;

    logic [15:0] mag_abs;
    logic        rnd_inc;
    logic [10:0] mant_sum;

    // 16-bit wrap makes -32768 come out as 0x8000, which is exactly its magnitude.
    assign mag_abs  = mag[15] ? (~mag + 16'd1) : mag;
    // Round to nearest even: guard set and either an odd lsb or any sticky bit.
    assign rnd_inc  = mag[4] & (mag[5] | (|mag[3:0]));
    assign mant_sum = {1'b0, mag[14:5]} + {10'd0, rnd_inc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req_q <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign   <= 1'b0;
            mag    <= 16'd0;
            exp_q  <= 5'd0;
            mant_q <= 10'd0;
            res_q  <= 16'd0;
        end else begin
            case (state)
                RD_HI: mag[15:8] <= dm_rdata;
                RD_LO: mag[7:0]  <= dm_rdata;
                ABS: begin
                    sign  <= mag[15];
                    mag   <= mag_abs;
                    exp_q <= 5'd30;
                end
                NORM: begin
                    mag   <= {mag[14:0], 1'b0};
                    exp_q <= exp_q - 5'd1;
                end
                ROUND: begin
                    // Carry out of the mantissa renormalizes to 1.0 x 2^(exp+1);
                    // exp never exceeds 30 here, so no overflow to infinity.
                    if (mant_sum[10]) begin
                        mant_q <= 10'd0;
                        exp_q  <= exp_q + 5'd1;
                    end else begin
                        mant_q <= mant_sum[9:0];
                    end
                end
                PACK: res_q <= (mag == 16'd0) ? 16'd0 : {sign, exp_q, mant_q};
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        dm_wr_en  = 1'b0;
        dm_addr   = IN_HI;
        dm_wdata  = 8'd0;
        unique case (state)
            IDLE:  if (req_q && !req) state_nxt = RD_HI;
            RD_HI: state_nxt = RD_LO;
            RD_LO: begin
                dm_addr   = IN_LO;
                state_nxt = ABS;
            end
            ABS: begin
                // Decide on the post-abs value so NORM is only entered when a shift is due.
                if (mag_abs == 16'd0)  state_nxt = PACK;
                else if (mag_abs[15])  state_nxt = ROUND;
                else                   state_nxt = NORM;
            end
            // Every NORM cycle shifts; leave once the shifted value will be normalized.
            NORM:  if (mag[14]) state_nxt = ROUND;
            ROUND: state_nxt = PACK;
            PACK:  state_nxt = WR_HI;
            WR_HI: begin
                dm_addr   = OUT_HI;
                dm_wdata  = res_q[15:8];
                dm_wr_en  = 1'b1;
                state_nxt = WR_LO;
            end
            WR_LO: begin
                dm_addr   = OUT_LO;
                dm_wdata  = res_q[7:0];
                dm_wr_en  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/int2flt_seq.md
Name: int2flt_seq

Overview:
- Sequential 16-bit two's-complement integer to IEEE-754 half-precision converter.
- Inverse direction of the float-to-int program.
- Sits beside data_mem under the same req/ack test-bench handshake.
- Reads the integer from data memory (MSB byte first), normalizes one bit per cycle, rounds to nearest even, writes the half-float back to memory, then pulses ack.

Parameters:
AW, 8, data memory address width
IN_ADDR, 0, address of integer MSB byte (LSB at IN_ADDR+1)
OUT_ADDR, 2, address of result MSB byte (LSB at OUT_ADDR+1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  test-bench request; conversion starts on its falling edge
ack  output  1  one-cycle completion pulse
dm_addr  output  AW  data memory address
dm_wr_en  output  1  data memory write enable
dm_wdata  output  8  data memory write data
dm_rdata  input  8  data memory read data; combinational, valid same cycle as dm_addr

Behaviour:
- Reset (reset low, async): state=IDLE; ack=0, dm_wr_en=0, dm_addr=IN_ADDR, dm_wdata=0; req_q=0; datapath registers cleared.
- Start detect: req_q registers req each cycle. Start when req_q=1 and req=0, in IDLE only. Edges during any other state are ignored.
- RD_HI: dm_addr=IN_ADDR; capture dm_rdata into mag[15:8].
- RD_LO: dm_addr=IN_ADDR+1; capture dm_rdata into mag[7:0].
- ABS:
  - sign=mag[15].
  - If sign=1, mag=~mag+1 as a 16-bit unsigned value; 0x8000 stays 0x8000 = 32768.
  - exp=30.
  - If mag==0, go to PACK with result forced to 0x0000.
- NORM:
  - While mag[15]==0: shift mag left 1, exp-=1, one bit per cycle.
  - Exit when mag[15]==1.
  - Up to 15 cycles; exp ends in 15..30.
- ROUND:
  - mant=mag[14:5], lsb=mag[5], guard=mag[4], sticky=|mag[3:0].
  - Increment mant if guard & (lsb | sticky).
  - If mant carries out, mant=0 and exp+=1. Max exp reachable is 30, so there is no infinity case.
- PACK: res={sign, exp[4:0], mant[9:0]}.
- WR_HI: dm_addr=OUT_ADDR, dm_wdata=res[15:8], dm_wr_en=1.
- WR_LO: dm_addr=OUT_ADDR+1, dm_wdata=res[7:0], dm_wr_en=1.
- DONE: ack=1 for exactly one cycle, dm_wr_en=0, then IDLE.
- dm_wr_en is high only in WR_HI and WR_LO, one cycle each. Memory inputs IN_ADDR/IN_ADDR+1 are never written.
- Latency, start-detect cycle to ack:
  - 7 cycles + number of NORM shifts.
  - Zero input skips NORM and ROUND: ack on cycle 6.
  - Worst case is input 1 or -1 (15 shifts).
- Reset mid-operation: FSM returns to IDLE immediately. Any pending write is abandoned; a partially written result (HI written, LO not) is permitted. No ack.
- req held high indefinitely: no start. Back-to-back requests are honored after ack, once IDLE is re-entered.
- exp and mant registers are sized exactly (5 and 10 bits, plus carry bit). Shifts are logical, zero-fill.

Test Plan:
- mem[0..1]=0x00,0x01 (1) -> 15 NORM shifts, mem[2..3]=0x3C,0x00, ack at cycle 22 after start.
- mem[0..1]=0xFF,0xFF (-1) -> 0xBC00; 0x00,0x00 (0) -> 0x0000 with ack at cycle 6, NORM never entered.
- 0x7FFF (32767) -> round-up carry into exponent -> 0x7800.
- 0x8000 (-32768) -> 0xF800, no NORM shifts.
- Tie cases:
  - 0x0801 (2049): guard=1, sticky=0, lsb=0 -> no round -> 0x6800.
  - 0x0803 (2051): tie with lsb=1 -> 0x6802.
- Assert reset low during NORM of a conversion of 0x0001:
  - Outputs reach reset values with no clock edge.
  - No ack; mem[2..3] unchanged.
  - A following req falling edge converts correctly.
  - A req pulse issued while busy is ignored (only one ack observed).
